// File: rtl/risc231_pkg.sv
// rtl/risc231_pkg.sv - shared types and constants for the RISC231 ID/EX issue stage
package risc231_pkg;

   localparam logic [3:0] ALU_ADD = 4'd0;

   typedef enum logic [1:0] {
      FWD_RF,
      FWD_EX,
      FWD_MEM
   } fwd_sel_e;

   typedef struct packed {
      logic        valid;
      logic        wr_en;
      logic        is_load;
      logic [4:0]  rd;
      logic [3:0]  aluop;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] store_data;
   } ex_bundle_t;

   localparam ex_bundle_t EX_BUBBLE = '{
      valid:      1'b0,
      wr_en:      1'b0,
      is_load:    1'b0,
      rd:         5'd0,
      aluop:      ALU_ADD,
      a:          32'd0,
      b:          32'd0,
      store_data: 32'd0
   };

endpackage

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - decode, writer and EX-side signals of the ID/EX issue stage
interface alu_issue_if;
   logic        id_valid;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_rs1_used;
   logic        id_rs2_used;
   logic [31:0] id_rs1_val;
   logic [31:0] id_rs2_val;
   logic [31:0] id_imm;
   logic        id_alusrc;
   logic [3:0]  id_aluop;
   logic [4:0]  id_rd;
   logic        id_wr_en;
   logic        id_is_load;
   logic [31:0] ex_result;
   logic        mem_wr_en;
   logic [4:0]  mem_rd;
   logic [31:0] mem_result;
   logic        flush;
   logic        id_stall;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  aluop;
   logic [4:0]  ex_rd;
   logic        ex_wr_en;
   logic        ex_is_load;
   logic        ex_valid;
   logic [31:0] ex_store_data;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rs1_val, id_rs2_val,
             id_imm, id_alusrc, id_aluop, id_rd, id_wr_en, id_is_load,
             ex_result, mem_wr_en, mem_rd, mem_result, flush,
      input  id_stall, A, B, aluop, ex_rd, ex_wr_en, ex_is_load, ex_valid, ex_store_data
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rs1_val, id_rs2_val,
             id_imm, id_alusrc, id_aluop, id_rd, id_wr_en, id_is_load,
             ex_result, mem_wr_en, mem_rd, mem_result, flush,
      output id_stall, A, B, aluop, ex_rd, ex_wr_en, ex_is_load, ex_valid, ex_store_data
   );
endinterface

// File: rtl/operand_forward.sv
// rtl/operand_forward.sv - per-operand bypass select and load-use detection
module operand_forward
   import risc231_pkg::*;
(
   input  logic [4:0]  rs,
   input  logic        used,
   input  logic [31:0] rf_val,
   input  logic        ex_valid,
   input  logic        ex_wr_en,
   input  logic        ex_is_load,
   input  logic [4:0]  ex_rd,
   input  logic [31:0] ex_result,
   input  logic        mem_wr_en,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_result,
   output logic [31:0] fwd_val,
   output fwd_sel_e    fwd_sel,
   output logic        load_hazard
);

   logic live;
   assign live = used && (rs != 5'd0);

   // EX is the younger writer, so it is checked before MEM
   always_comb begin
      fwd_sel = FWD_RF;
      fwd_val = rf_val;
      if (live && ex_valid && ex_wr_en && !ex_is_load && (ex_rd == rs)) begin
         fwd_sel = FWD_EX;
         fwd_val = ex_result;
      end else if (live && mem_wr_en && (mem_rd == rs)) begin
         fwd_sel = FWD_MEM;
         fwd_val = mem_result;
      end
   end

   assign load_hazard = live && ex_valid && ex_wr_en && ex_is_load && (ex_rd == rs);

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ID/EX register with operand forwarding and load-use bubble insertion
module alu_issue
   import risc231_pkg::*;
(
   input logic        clock,
   input logic        reset_n,
   alu_issue_if.slave bus
);

   ex_bundle_t  ex_q;
   ex_bundle_t  ex_d;
   logic [31:0] fwd1;
   logic [31:0] fwd2;
   fwd_sel_e    rs1_sel_unused;
   fwd_sel_e    rs2_sel_unused;
   logic        lh1;
   logic        lh2;
   logic        hazard;

   operand_forward u_fwd_rs1 (
      .rs(bus.id_rs1), .used(bus.id_rs1_used), .rf_val(bus.id_rs1_val),
      .ex_valid(ex_q.valid), .ex_wr_en(ex_q.wr_en), .ex_is_load(ex_q.is_load),
      .ex_rd(ex_q.rd), .ex_result(bus.ex_result),
      .mem_wr_en(bus.mem_wr_en), .mem_rd(bus.mem_rd), .mem_result(bus.mem_result),
      .fwd_val(fwd1), .fwd_sel(rs1_sel_unused), .load_hazard(lh1)
   );

   operand_forward u_fwd_rs2 (
      .rs(bus.id_rs2), .used(bus.id_rs2_used), .rf_val(bus.id_rs2_val),
      .ex_valid(ex_q.valid), .ex_wr_en(ex_q.wr_en), .ex_is_load(ex_q.is_load),
      .ex_rd(ex_q.rd), .ex_result(bus.ex_result),
      .mem_wr_en(bus.mem_wr_en), .mem_rd(bus.mem_rd), .mem_result(bus.mem_result),
      .fwd_val(fwd2), .fwd_sel(rs2_sel_unused), .load_hazard(lh2)
   );

   assign hazard       = bus.id_valid && (lh1 || lh2);
   // a flush already discards the bundle, so decode need not hold it
   assign bus.id_stall = hazard && !bus.flush;

   always_comb begin
      ex_d = EX_BUBBLE;
      if (!bus.flush && !hazard) begin
         ex_d.valid      = bus.id_valid;
         ex_d.wr_en      = bus.id_valid && bus.id_wr_en;
         ex_d.is_load    = bus.id_is_load;
         ex_d.rd         = bus.id_rd;
         ex_d.aluop      = bus.id_aluop;
         ex_d.a          = fwd1;
         ex_d.b          = bus.id_alusrc ? bus.id_imm : fwd2;
         ex_d.store_data = fwd2;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ex_q <= EX_BUBBLE;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign bus.A             = ex_q.a;
   assign bus.B             = ex_q.b;
   assign bus.aluop         = ex_q.aluop;
   assign bus.ex_rd         = ex_q.rd;
   assign bus.ex_wr_en      = ex_q.wr_en;
   assign bus.ex_is_load    = ex_q.is_load;
   assign bus.ex_valid      = ex_q.valid;
   assign bus.ex_store_data = ex_q.store_data;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed and randomized checks of alu_issue against a spec-level model
module tb_alu_issue;
   import risc231_pkg::*;

   logic clock;
   logic reset_n;
   int   checks;
   int   failures;

   alu_issue_if bus ();

   alu_issue dut (.clock(clock), .reset_n(reset_n), .bus(bus));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // expected content of the EX-side register
   logic        m_valid, m_wr_en, m_is_load;
   logic [4:0]  m_rd;
   logic [3:0]  m_aluop;
   logic [31:0] m_a, m_b, m_sd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_bubble();
      m_valid = 0; m_wr_en = 0; m_is_load = 0; m_rd = 0;
      m_aluop = ALU_ADD; m_a = 0; m_b = 0; m_sd = 0;
   endtask

   function automatic logic [31:0] fwd(input logic [4:0] rs, input logic used, input logic [31:0] rfv);
      if (!used || rs == 0) return rfv;
      if (m_valid && m_wr_en && !m_is_load && m_rd == rs) return bus.ex_result;
      if (bus.mem_wr_en && bus.mem_rd == rs) return bus.mem_result;
      return rfv;
   endfunction

   task automatic chk_outputs();
      chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
      chk("ex_wr_en", 32'(bus.ex_wr_en), 32'(m_wr_en));
      chk("ex_is_load", 32'(bus.ex_is_load), 32'(m_is_load));
      chk("ex_rd", 32'(bus.ex_rd), 32'(m_rd));
      chk("aluop", 32'(bus.aluop), 32'(m_aluop));
      chk("A", bus.A, m_a);
      chk("B", bus.B, m_b);
      chk("store_data", bus.ex_store_data, m_sd);
   endtask

   // settle, check the stall, predict, clock, compare
   task automatic step();
      logic        hz;
      logic [31:0] f1, f2;
      #1;
      hz = bus.id_valid && m_valid && m_is_load && m_wr_en && m_rd != 0 &&
           ((bus.id_rs1_used && bus.id_rs1 == m_rd) || (bus.id_rs2_used && bus.id_rs2 == m_rd));
      chk("id_stall", 32'(bus.id_stall), 32'(hz && !bus.flush));
      f1 = fwd(bus.id_rs1, bus.id_rs1_used, bus.id_rs1_val);
      f2 = fwd(bus.id_rs2, bus.id_rs2_used, bus.id_rs2_val);
      if (bus.flush || hz) begin
         model_bubble();
      end else begin
         m_valid = bus.id_valid;
         m_wr_en = bus.id_valid && bus.id_wr_en;
         m_is_load = bus.id_is_load;
         m_rd = bus.id_rd;
         m_aluop = bus.id_aluop;
         m_a = f1;
         m_b = bus.id_alusrc ? bus.id_imm : f2;
         m_sd = f2;
      end
      @(posedge clock);
      #1;
      chk_outputs();
   endtask

   task automatic bundle(input logic v, input logic [4:0] rs1, input logic u1, input logic [31:0] v1,
                         input logic [4:0] rs2, input logic u2, input logic [31:0] v2,
                         input logic [4:0] rd, input logic wr, input logic ld);
      bus.id_valid = v;
      bus.id_rs1 = rs1; bus.id_rs1_used = u1; bus.id_rs1_val = v1;
      bus.id_rs2 = rs2; bus.id_rs2_used = u2; bus.id_rs2_val = v2;
      bus.id_rd = rd; bus.id_wr_en = wr; bus.id_is_load = ld;
      bus.id_imm = 32'h0000_0040; bus.id_alusrc = 0; bus.id_aluop = 4'h3;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset_n = 0;
      bundle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      bus.ex_result = 0; bus.mem_wr_en = 0; bus.mem_rd = 0; bus.mem_result = 0; bus.flush = 0;
      model_bubble();
      #12;
      chk_outputs();
      chk("reset_aluop", 32'(bus.aluop), 32'(ALU_ADD));
      reset_n = 1;

      // EX forward
      bundle(1, 1, 1, 32'h1, 2, 1, 32'h2, 5, 1, 0);
      step();
      bundle(1, 5, 1, 32'h0, 0, 0, 32'h0, 6, 1, 0);
      bus.ex_result = 32'h0000_0011;
      step();
      chk("ex_fwd_A", bus.A, 32'h0000_0011);

      // EX beats MEM on the same register
      bundle(1, 1, 1, 32'h1, 2, 1, 32'h2, 7, 1, 0);
      step();
      bundle(1, 0, 0, 32'h0, 7, 1, 32'h0, 8, 1, 0);
      bus.mem_wr_en = 1; bus.mem_rd = 7; bus.mem_result = 32'hAAAA_AAAA;
      bus.ex_result = 32'h5555_5555;
      step();
      chk("ex_over_mem_B", bus.B, 32'h5555_5555);
      bus.mem_wr_en = 0;

      // x0 never forwards
      bundle(1, 1, 1, 32'h1, 2, 1, 32'h2, 0, 1, 0);
      step();
      bundle(1, 0, 1, 32'h0, 0, 0, 32'h0, 9, 1, 0);
      bus.ex_result = 32'hFFFF_FFFF;
      step();
      chk("x0_A", bus.A, 32'h0);

      // load-use: one stall, then MEM forward
      bundle(1, 1, 1, 32'h1, 2, 1, 32'h2, 3, 1, 1);
      step();
      bundle(1, 3, 1, 32'h0, 4, 1, 32'h4, 10, 1, 0);
      #1 chk("lu_stall", 32'(bus.id_stall), 32'd1);
      step();
      chk("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
      bus.mem_wr_en = 1; bus.mem_rd = 3; bus.mem_result = 32'h0000_1234;
      #1 chk("lu_release_stall", 32'(bus.id_stall), 32'd0);
      step();
      chk("lu_mem_A", bus.A, 32'h0000_1234);
      chk("lu_valid", 32'(bus.ex_valid), 32'd1);
      bus.mem_wr_en = 0;

      // flush beats hazard
      bundle(1, 1, 1, 32'h1, 2, 1, 32'h2, 3, 1, 1);
      step();
      bundle(1, 3, 1, 32'h0, 4, 1, 32'h4, 10, 1, 0);
      bus.flush = 1;
      #1 chk("flush_stall", 32'(bus.id_stall), 32'd0);
      step();
      chk("flush_valid", 32'(bus.ex_valid), 32'd0);
      bus.flush = 0;

      // async reset while stalled
      bundle(1, 1, 1, 32'h1, 2, 1, 32'h2, 3, 1, 1);
      step();
      bundle(1, 3, 1, 32'h0, 4, 1, 32'h4, 11, 1, 0);
      #1 chk("pre_reset_stall", 32'(bus.id_stall), 32'd1);
      reset_n = 0;
      #1;
      model_bubble();
      chk_outputs();
      chk("reset_stall", 32'(bus.id_stall), 32'd0);
      reset_n = 1;
      step();
      chk("post_reset_valid", 32'(bus.ex_valid), 32'd1);

      // unused source never stalls
      bundle(1, 1, 1, 32'h1, 2, 1, 32'h2, 3, 1, 1);
      step();
      bundle(1, 3, 0, 32'h0, 3, 0, 32'h0, 12, 1, 0);
      #1 chk("unused_no_stall", 32'(bus.id_stall), 32'd0);
      step();

      for (int i = 0; i < 400; i++) begin
         bundle(($urandom % 8) != 0,
                5'($urandom_range(0, 3)), ($urandom % 4) != 0, $urandom,
                5'($urandom_range(0, 3)), ($urandom % 4) != 0, $urandom,
                5'($urandom_range(0, 3)), $urandom % 2, ($urandom % 3) == 0);
         bus.id_imm = $urandom;
         bus.id_alusrc = $urandom % 2;
         bus.id_aluop = 4'($urandom);
         bus.ex_result = $urandom;
         bus.mem_wr_en = $urandom % 2;
         bus.mem_rd = 5'($urandom_range(0, 3));
         bus.mem_result = $urandom;
         bus.flush = ($urandom % 8) == 0;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
